// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter that shares one register write port among NREQ requesters.
// Optional release timeout with sticky err flag: define ARB_REL_TIMEOUT_EN.
module reg_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        grant_id,
  output logic [WIDTH-1:0]      state_din,
  output logic                  state_wen,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] data_arr [NREQ];
  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [IDW:0]     cand_sum_s;
  logic [IDW-1:0]   cand_s;

`ifdef ARB_REL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Unpack the flat data bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found_s    = 1'b0;
    win_s      = '0;
    cand_sum_s = '0;
    cand_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum_s >= (IDW+1)'(NREQ)) begin
        cand_sum_s = cand_sum_s - (IDW+1)'(NREQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_s = cand_sum_s[IDW-1:0];
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the IDLE / WRITE / RELEASE sequence.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    din_d      = din_q;
`ifdef ARB_REL_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = WRITE;
          grant_id_d = win_s;
          din_d      = data_arr[win_s];
        end else begin
          state_d    = IDLE;
        end
      end
      WRITE: begin
        state_d = RELEASE;
        if (grant_id_q == IDW'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_id_q + IDW'(1);
        end
`ifdef ARB_REL_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      RELEASE: begin
`ifdef ARB_REL_TIMEOUT_EN
        // Leaving on the TIMEOUT-th held cycle gives exactly TIMEOUT cycles in RELEASE.
        if (!req[grant_id_q]) begin
          state_d = IDLE;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q + CW'(1);
        end
`else
        if (!req[grant_id_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      din_q      <= '0;
`ifdef ARB_REL_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      din_q      <= din_d;
`ifdef ARB_REL_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  // Write strobe and grant decode; gated so nothing is written while reset is high.
  always_comb begin
    gnt       = '0;
    state_wen = 1'b0;
    if ((state_q == WRITE) && !reset) begin
      gnt[grant_id_q] = 1'b1;
      state_wen       = 1'b1;
    end else begin
      state_wen       = 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign state_din = din_q;
`ifdef ARB_REL_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter; expected writes are queued and matched as they appear.
module tb_reg_wr_arbiter;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        grant_id;
  logic [WIDTH-1:0]      state_din;
  logic                  state_wen;
  logic                  busy;
  logic                  err;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t              exp_q[$];
  wr_t              exp_w;
  logic [WIDTH-1:0] tgt_q;
  int               checks = 0;
  int               errors = 0;
  int               n;
  int               rel;
  int               hold [NREQ];

  reg_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .grant_id(grant_id), .state_din(state_din), .state_wen(state_wen),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDW-1:0] id, input logic [WIDTH-1:0] d);
    wr_t w;
    w.id   = id;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_idle(input int lim);
    for (int c = 0; c < lim && busy !== 1'b0; c++) step();
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  // Target register model driven by the arbiter's write port.
  always @(posedge clk) begin
    if (state_wen === 1'b1) tgt_q <= state_din;
  end

  // Scoreboard: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (state_wen === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed id %0d data 0x%0h expected no write", grant_id, state_din);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sb_id", 32'(grant_id), 32'(exp_w.id));
        check("sb_data", 32'(state_din), 32'(exp_w.data));
        check("sb_gnt", 32'(gnt), 32'd1 << exp_w.id);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    req      = 4'b1111;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) hold[i] = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_wen", 32'(state_wen), 32'd0);
      check("rst_din", 32'(state_din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request
    set_data(0, 8'hA5);
    req = 4'b0001;
    push(2'd0, 8'hA5);
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_wen", 32'(state_wen), 32'd1);
    check("single_din", 32'(state_din), 32'hA5);
    check("single_gid", 32'(grant_id), 32'd0);
    req = 4'b0000;
    step();
    check("single_oneshot", 32'(state_wen), 32'd0);
    check("single_busy_rel", 32'(busy), 32'd1);
    step();
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_tgt", 32'(tgt_q), 32'hA5);

    // Rotation with all requesters active, starting from ptr=0
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'h10 + 8'(i));
    req = 4'b1111;
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12); push(2'd3, 8'h13); push(2'd0, 8'h10);
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) req[i] = 1'b1;
        end
      end
      if (state_wen === 1'b1) begin
        n++;
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            req[i]  = 1'b0;
            hold[i] = 2;
          end
        end
      end
    end
    check("rot_count", 32'(n), 32'd5);
    req = 4'b0000;
    wait_idle(10);

    // Pointer priority: ptr=1, so requester 2 beats requester 0
    set_data(0, 8'h40);
    set_data(2, 8'h42);
    req = 4'b0101;
    push(2'd2, 8'h42);
    push(2'd0, 8'h40);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      step();
      if (state_wen === 1'b1) begin
        n++;
        if (n == 1) check("prio_first", 32'(grant_id), 32'd2);
        req = req & ~gnt;
      end
    end
    check("prio_count", 32'(n), 32'd2);
    wait_idle(10);

    // Release blocking: requester 1 holds while 3 waits
    set_data(1, 8'h51);
    set_data(3, 8'h53);
    req = 4'b1010;
    push(2'd1, 8'h51);
    push(2'd3, 8'h53);
    step();
    check("blk_gnt1", 32'(gnt), 32'h2);
    for (int c = 0; c < 6; c++) begin
      step();
      check("blk_no_wen", 32'(state_wen), 32'd0);
    end
    req[1] = 1'b0;
    step();
    check("blk_idle_wen", 32'(state_wen), 32'd0);
    check("blk_idle_busy", 32'(busy), 32'd0);
    step();
    check("blk_gnt3", 32'(gnt), 32'h8);
    req[3] = 1'b0;
    wait_idle(10);

    // Reset during RELEASE
    set_data(2, 8'h62);
    req = 4'b0100;
    push(2'd2, 8'h62);
    step();
    check("rr_wen", 32'(state_wen), 32'd1);
    step();
    check("rr_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rr_gate_wen", 32'(state_wen), 32'd0);
    check("rr_gate_gnt", 32'(gnt), 32'd0);
    step();
    check("rr_busy_rst", 32'(busy), 32'd0);
    check("rr_gid_rst", 32'(grant_id), 32'd0);
    check("rr_din_rst", 32'(state_din), 32'd0);
    reset = 1'b0;
    set_data(1, 8'h71);
    set_data(3, 8'h73);
    req = 4'b1010;
    push(2'd1, 8'h71);
    step();
    check("rst_ptr0", 32'(grant_id), 32'd1);
    req = 4'b0000;
    wait_idle(10);

    // Reset during WRITE: strobe is suppressed and the register keeps its value
    set_data(2, 8'h64);
    req = 4'b0100;
    step();
    check("rw_gid", 32'(grant_id), 32'd2);
    reset = 1'b1;
    #1;
    check("rw_gate_wen", 32'(state_wen), 32'd0);
    check("rw_gate_gnt", 32'(gnt), 32'd0);
    step();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_tgt", 32'(tgt_q), 32'h71);
    req   = 4'b0000;
    reset = 1'b0;
    step();

`ifdef ARB_REL_TIMEOUT_EN
    // Stuck requester 0 times out; pending requester 2 is then served
    set_data(0, 8'h81);
    set_data(2, 8'h82);
    req = 4'b0101;
    push(2'd0, 8'h81);
    push(2'd2, 8'h82);
    step();
    check("tmo_gnt0", 32'(gnt), 32'h1);
    rel = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      step();
      if (busy === 1'b1 && state_wen === 1'b0) rel++;
    end
    check("tmo_cycles", 32'(rel), 32'(TIMEOUT));
    check("tmo_err", 32'(err), 32'd1);
    step();
    check("tmo_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    wait_idle(10);
    check("tmo_err_sticky", 32'(err), 32'd1);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Round-robin write arbiter that lets NREQ requesters share the single write port of a state register (state_din / state_wen / state_dout register in lab6). It picks one requester, latches that requester's data and issues a one-cycle write strobe plus a grant pulse. It then waits for the winner to release before serving the next requester. It sits between the requesting FSMs and the register and drives that register's write port directly.

Parameters:
WIDTH, 8, data width; matches the target register width.
NREQ, 4, number of requesters; legal range 2..8.
IDW, 2, grant index width; must equal clog2(NREQ).
TIMEOUT, 15, release-timeout limit in cycles; used only with the optional feature.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
req  input  NREQ  request per requester; held until the requester sees its gnt, then dropped.
req_data  input  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
gnt  output  NREQ  one-hot grant pulse; high only in the WRITE cycle.
grant_id  output  IDW  index of the current or last winner.
state_din  output  WIDTH  data to the target register.
state_wen  output  1  write enable to the target register.
busy  output  1  high whenever the FSM is not in IDLE.
err  output  1  sticky release-timeout flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (sampled at posedge):
  - state=IDLE, ptr=0, grant_id=0, state_din=0, err=0.
  - gnt, state_wen and busy are all 0.
  - gnt and state_wen are gated by !reset, so no write is ever issued in a cycle where reset is high.
- FSM has three states: IDLE, WRITE, RELEASE.
- IDLE:
  - If req != 0, the winner is the first requester with req set, searching from index ptr upward and wrapping modulo NREQ.
  - Latch the winner's index into grant_id and its req_data slice into state_din, then go to WRITE.
  - If req == 0, stay in IDLE; state_din and grant_id hold their values.
- WRITE (exactly one cycle):
  - state_wen=1 and gnt[grant_id]=1; all other gnt bits are 0.
  - ptr <= (grant_id+1) mod NREQ.
  - Next state is RELEASE.
- RELEASE:
  - gnt=0, state_wen=0.
  - Stay while req[grant_id]=1. Go to IDLE in the cycle after req[grant_id] is sampled 0.
  - Other requests are ignored in this state and remain pending.
- Latency:
  - req first sampled high in IDLE at edge c → gnt/state_wen high during cycle c+1; the target register updates at the end of c+1.
  - Minimum spacing between two grants is 3 cycles (IDLE, WRITE, RELEASE).
- Data stability: state_din is taken only at the IDLE→WRITE edge. Changes on req_data afterwards do not affect the current write.
- Output timing: busy, gnt and state_wen are decoded from registered state and are glitch-free. state_din is stable throughout WRITE.
- Fairness: a requester granted once cannot be granted again until every other requester that was pending at the next arbitration has been served.
- Boundary conditions:
  - All requesters active: grant order is strict rotation starting from ptr.
  - ptr wrap: NREQ-1 → 0.
  - Reset in WRITE or RELEASE: the FSM goes to IDLE with ptr=0 on the next edge, and no write is issued in the reset cycle.
  - req deasserted by a non-winner while it is waiting: the request is simply dropped.

Optional Feature:
Macro ARB_REL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RELEASE and increments each cycle while req[grant_id] stays high.
  - When the counter reaches TIMEOUT, the FSM goes to IDLE regardless of req, and err is set.
  - ptr was already advanced in WRITE, so the stuck requester loses priority.
  - err remains set until reset.
- Not defined: there is no counter, err is tied to 0, and RELEASE waits indefinitely.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with req=4'b1111 → gnt=0, state_wen=0, state_din=0, busy=0, grant_id=0 throughout.
2. Single request: req=4'b0001 with data0=8'hA5 → next cycle gnt=0001, state_wen=1, state_din=8'hA5, grant_id=0, for exactly one cycle. Then drop req → busy falls 2 cycles later and the target register reads 8'hA5.
3. Rotation: hold all 4 requests; each requester drops req one cycle after its gnt and re-asserts one cycle later, with data i = 8'h10+i → writes occur in order 0,1,2,3,0 with state_din 8'h10, 11, 12, 13, 10.
4. Pointer priority: after a grant to requester 0 (ptr=1), assert req=4'b0101 → requester 2 wins first, then requester 0.
5. Release blocking: requester 1 keeps req high for 6 cycles after its gnt while requester 3 waits → no state_wen during that time. After requester 1 drops req, requester 3 is granted 2 cycles later.
6. Reset and timeout: reset during RELEASE → IDLE next cycle, ptr=0, no write issued. With ARB_REL_TIMEOUT_EN and TIMEOUT=15, keep req high after gnt → return to IDLE after 15 RELEASE cycles, err=1, and a pending requester is then granted.
